// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle main FSM (master) and the shared datapath (slave).
// The opcode, zero and mem_ready signals flow into the FSM; all enables and selects flow out of it.
interface multicycle_control_if #(
  parameter int STATE_W = 4
);
  logic [6:0]         opcode;
  logic               zero;
  logic               mem_ready;
  logic               mem_req;
  logic               mem_write;
  logic               adr_src;
  logic               ir_write;
  logic               pc_write;
  logic [1:0]         alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         alu_op;
  logic               funct7_valid;
  logic [1:0]         result_src;
  logic               reg_write;
  logic               illegal_op;
  logic [STATE_W-1:0] state_o;

  modport master (
    input  opcode, zero, mem_ready,
    output mem_req, mem_write, adr_src, ir_write, pc_write, alu_src_a, alu_src_b,
           alu_op, funct7_valid, result_src, reg_write, illegal_op, state_o
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  mem_req, mem_write, adr_src, ir_write, pc_write, alu_src_a, alu_src_b,
           alu_op, funct7_valid, result_src, reg_write, illegal_op, state_o
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RV32I core: sequences fetch, decode, execute,
// memory and writeback over one shared memory port and one ALU.
module multicycle_control #(
  parameter int STATE_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master bus
);

  typedef enum logic [STATE_W-1:0] {
    FETCH   = STATE_W'(0),
    DECODE  = STATE_W'(1),
    MEMADR  = STATE_W'(2),
    MEMRD   = STATE_W'(3),
    MEMWB   = STATE_W'(4),
    MEMWR   = STATE_W'(5),
    EXECR   = STATE_W'(6),
    EXECI   = STATE_W'(7),
    ALUWB   = STATE_W'(8),
    BEQ     = STATE_W'(9),
    JAL     = STATE_W'(10),
    ILLEGAL = STATE_W'(11)
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_BRAN  = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       funct7_valid;
    logic [1:0] result_src;
    logic       reg_write;
    logic       illegal_op;
  } ctrl_t;

  state_t state_reg;
  state_t state_next;
  ctrl_t  ctrl;
  ctrl_t  ctrl_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = FETCH;
    ctrl       = '0;
    case (state_reg)
      FETCH: begin
        ctrl.mem_req    = 1'b1;
        ctrl.alu_src_b  = 2'b10;
        ctrl.result_src = 2'b10;
        ctrl.ir_write   = bus.mem_ready;
        ctrl.pc_write   = bus.mem_ready;
        state_next      = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        // Branch target is computed here so BEQ can load PC straight from ALUOut.
        ctrl.alu_src_a = 2'b01;
        ctrl.alu_src_b = 2'b01;
        case (bus.opcode)
          OP_LOAD, OP_STORE: state_next = MEMADR;
          OP_REG:            state_next = EXECR;
          OP_IMM:            state_next = EXECI;
          OP_BRAN:           state_next = BEQ;
          OP_JAL:            state_next = JAL;
          default:           state_next = ILLEGAL;
        endcase
      end
      MEMADR: begin
        ctrl.alu_src_a = 2'b10;
        ctrl.alu_src_b = 2'b01;
        state_next     = (bus.opcode == OP_LOAD) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.adr_src = 1'b1;
        state_next   = bus.mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        ctrl.result_src = 2'b01;
        ctrl.reg_write  = 1'b1;
      end
      MEMWR: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.adr_src   = 1'b1;
        state_next     = bus.mem_ready ? FETCH : MEMWR;
      end
      EXECR: begin
        ctrl.alu_src_a    = 2'b10;
        ctrl.alu_op       = 2'b10;
        ctrl.funct7_valid = 1'b1;
        state_next        = ALUWB;
      end
      EXECI: begin
        // funct7 stays masked: immediate bit 30 must not turn ADDI into SUB.
        ctrl.alu_src_a = 2'b10;
        ctrl.alu_src_b = 2'b01;
        ctrl.alu_op    = 2'b10;
        state_next     = ALUWB;
      end
      ALUWB: begin
        ctrl.reg_write = 1'b1;
      end
      BEQ: begin
        ctrl.alu_src_a = 2'b10;
        ctrl.alu_op    = 2'b01;
        ctrl.pc_write  = bus.zero;
      end
      JAL: begin
        // PC takes the target from ALUOut while the ALU forms oldPC+4 for ALUWB.
        ctrl.alu_src_a = 2'b01;
        ctrl.alu_src_b = 2'b10;
        ctrl.pc_write  = 1'b1;
        state_next     = ALUWB;
      end
      ILLEGAL: begin
        ctrl.illegal_op = 1'b1;
      end
      default: begin
        ctrl       = '0;
        state_next = FETCH;
      end
    endcase
  end

  // Reset overrides the FETCH decode so nothing is requested while rst_n is low.
  assign ctrl_out = rst_n ? ctrl : '0;

  assign bus.mem_req      = ctrl_out.mem_req;
  assign bus.mem_write    = ctrl_out.mem_write;
  assign bus.adr_src      = ctrl_out.adr_src;
  assign bus.ir_write     = ctrl_out.ir_write;
  assign bus.pc_write     = ctrl_out.pc_write;
  assign bus.alu_src_a    = ctrl_out.alu_src_a;
  assign bus.alu_src_b    = ctrl_out.alu_src_b;
  assign bus.alu_op       = ctrl_out.alu_op;
  assign bus.funct7_valid = ctrl_out.funct7_valid;
  assign bus.result_src   = ctrl_out.result_src;
  assign bus.reg_write    = ctrl_out.reg_write;
  assign bus.illegal_op   = ctrl_out.illegal_op;
  assign bus.state_o      = rst_n ? state_reg : '0;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: a per-instruction step-list model queues the
// expected outputs of every cycle, and an independent monitor compares them mid-cycle.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_control_if #(.STATE_W(4)) bus ();
  multicycle_control #(.STATE_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       funct7_valid;
    logic [1:0] result_src;
    logic       reg_write;
    logic       illegal_op;
    logic [3:0] state;
  } obs_t;

  obs_t exp_q[$];
  bit   mr_q[$];
  int   zero_force = -1;
  int   total = 0;
  int   bad = 0;

  // Expected outputs of one step, straight from the state table.
  function automatic obs_t model_out(input int step, input bit mr, input bit z);
    obs_t o;
    o = '0;
    o.state = 4'(step);
    case (step)
      0:  begin o.mem_req = 1; o.alu_src_b = 2; o.result_src = 2; o.ir_write = mr; o.pc_write = mr; end
      1:  begin o.alu_src_a = 1; o.alu_src_b = 1; end
      2:  begin o.alu_src_a = 2; o.alu_src_b = 1; end
      3:  begin o.mem_req = 1; o.adr_src = 1; end
      4:  begin o.result_src = 1; o.reg_write = 1; end
      5:  begin o.mem_req = 1; o.mem_write = 1; o.adr_src = 1; end
      6:  begin o.alu_src_a = 2; o.alu_op = 2; o.funct7_valid = 1; end
      7:  begin o.alu_src_a = 2; o.alu_src_b = 1; o.alu_op = 2; end
      8:  begin o.reg_write = 1; end
      9:  begin o.alu_src_a = 2; o.alu_op = 1; o.pc_write = z; end
      10: begin o.alu_src_a = 1; o.alu_src_b = 2; o.pc_write = 1; end
      11: begin o.illegal_op = 1; end
      default: o = '0;
    endcase
    return o;
  endfunction

  // Step list each instruction class walks through (-1 ends it).
  function automatic int seq_step(input logic [6:0] op, input int idx);
    int s[5];
    case (op)
      7'b0000011: s = '{0, 1, 2, 3, 4};
      7'b0100011: s = '{0, 1, 2, 5, -1};
      7'b0110011: s = '{0, 1, 6, 8, -1};
      7'b0010011: s = '{0, 1, 7, 8, -1};
      7'b1100011: s = '{0, 1, 9, -1, -1};
      7'b1101111: s = '{0, 1, 10, 8, -1};
      default:    s = '{0, 1, 11, -1, -1};
    endcase
    return (idx < 5) ? s[idx] : -1;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.mem_req      = bus.mem_req;
    o.mem_write    = bus.mem_write;
    o.adr_src      = bus.adr_src;
    o.ir_write     = bus.ir_write;
    o.pc_write     = bus.pc_write;
    o.alu_src_a    = bus.alu_src_a;
    o.alu_src_b    = bus.alu_src_b;
    o.alu_op       = bus.alu_op;
    o.funct7_valid = bus.funct7_valid;
    o.result_src   = bus.result_src;
    o.reg_write    = bus.reg_write;
    o.illegal_op   = bus.illegal_op;
    o.state        = bus.state_o;
    return o;
  endfunction

  // Monitor: pops one expectation per cycle, sampled 2 time units after the falling edge.
  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = sample();
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL outputs t=%0t exp_state=%0d got_state=%0d actual=%h required=%h",
                   $time, e.state, a.state, a, e);
        end
      end
    end
  end

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst_n = 1'b0;
      bus.mem_ready = 1'($urandom_range(0, 1));
      bus.zero = 1'($urandom_range(0, 1));
      exp_q.push_back('0);
    end
  endtask

  // Drives one instruction; max_cycles > 0 abandons it early (used to reset mid-stall).
  task automatic run_instr(input logic [6:0] op, input int max_cycles);
    int idx;
    int step;
    int cycles;
    bit mr;
    bit z;
    idx = 0;
    cycles = 0;
    step = seq_step(op, 0);
    while (step != -1 && (max_cycles == 0 || cycles < max_cycles)) begin
      @(negedge clk);
      rst_n = 1'b1;
      if (cycles == 0) bus.opcode = op;
      mr = (mr_q.size() > 0) ? mr_q.pop_front() : ($urandom_range(0, 3) != 0);
      z = (zero_force >= 0) ? zero_force[0] : 1'($urandom_range(0, 1));
      bus.mem_ready = mr;
      bus.zero = z;
      exp_q.push_back(model_out(step, mr, z));
      cycles++;
      if (!((step == 0 || step == 3 || step == 5) && !mr)) begin
        idx++;
        step = seq_step(op, idx);
      end
    end
    $display("instr op=%b cycles=%0d%s", op, cycles, (step != -1) ? " (abandoned)" : "");
  endtask

  logic [6:0] ops[7];

  initial begin
    logic [6:0] op;
    bus.opcode = '0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111, 7'b1110011};

    do_reset(3);

    // lw: two FETCH stalls and one MEMRD stall.
    mr_q = '{0, 0, 1, 1, 1, 0, 1, 1};
    run_instr(7'b0000011, 0);

    // beq taken then not taken.
    mr_q = '{1, 1, 1};
    zero_force = 1;
    run_instr(7'b1100011, 0);
    mr_q = '{1, 1, 1};
    zero_force = 0;
    run_instr(7'b1100011, 0);
    zero_force = -1;

    mr_q = '{1, 1, 1, 1};
    run_instr(7'b0010011, 0);
    mr_q = '{1, 1, 1, 1};
    run_instr(7'b0110011, 0);
    mr_q = '{1, 1, 1, 1};
    run_instr(7'b1101111, 0);
    mr_q = '{1, 1, 1};
    run_instr(7'b1110011, 0);

    // sw stalled in MEMWR, then reset while the store is still pending.
    mr_q = '{1, 1, 1, 0, 0};
    run_instr(7'b0100011, 5);
    mr_q.delete();
    do_reset(2);
    mr_q = '{1, 1, 1, 1};
    run_instr(7'b0100011, 0);
    mr_q.delete();

    // Random instruction mix with random stalls, zero flags and stray opcodes.
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 7) == 0) op = 7'($urandom);
      else op = ops[$urandom_range(0, 6)];
      run_instr(op, 0);
      if ($urandom_range(0, 19) == 0) do_reset(1 + $urandom_range(0, 1));
    end

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain leftover=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle RV32I core.
- Sequences the shared datapath: one memory port, one ALU, PC/IR registers and register file. Each instruction walks through fetch, decode, execute, memory and writeback states.
- Drives the 2-bit ALUOp consumed by the ALU control decoder.
- Supports lw, sw, R-type ALU, I-type ALU, beq and jal. Stalls on a memory ready handshake.

Parameters:
- STATE_W, 4, width of the state register and state_o.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- opcode  input  7  IR[6:0]; stable from DECODE until the instruction retires.
- zero  input  1  ALU zero flag, same-cycle.
- mem_ready  input  1  memory accepted write / returned read data this cycle.
- mem_req  output  1  memory access request.
- mem_write  output  1  request is a store.
- adr_src  output  1  memory address: 0 = PC, 1 = ALUOut.
- ir_write  output  1  load IR and oldPC.
- pc_write  output  1  load PC from the result mux.
- alu_src_a  output  2  00 = PC, 01 = oldPC, 10 = rs1 data.
- alu_src_b  output  2  00 = rs2 data, 01 = immediate, 10 = constant 4.
- alu_op  output  2  00 = add, 01 = subtract, 10 = decode funct fields.
- funct7_valid  output  1  ALU decoder may use funct7 (R-type only).
- result_src  output  2  00 = ALUOut, 01 = memory data, 10 = ALU result.
- reg_write  output  1  register file write enable.
- illegal_op  output  1  one-cycle pulse on an unsupported opcode.
- state_o  output  STATE_W  current state, for debug and verification.

Behaviour:
- Reset: asynchronous; state = FETCH (0).
  - While rst_n = 0, all outputs are forced to 0, including state_o.
  - First active edge after release evaluates FETCH.
- Outputs are Moore decodes of state, except ir_write and pc_write, which also depend on mem_ready / zero as listed.
- Any output not listed for a state is 0. alu_op, alu_src_* and result_src are 00 unless listed.
- State encodings, outputs and transitions:
  - FETCH 0: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10; ir_write = pc_write = mem_ready. Stay while !mem_ready, else DECODE.
  - DECODE 1: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target into ALUOut). Next state by opcode:
    - 0000011 / 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - anything else -> ILLEGAL
  - MEMADR 2: alu_src_a=10, alu_src_b=01, alu_op=00. opcode 0000011 -> MEMRD, else MEMWR.
  - MEMRD 3: mem_req=1, adr_src=1. Stay until mem_ready, then MEMWB.
  - MEMWB 4: result_src=01, reg_write=1 -> FETCH.
  - MEMWR 5: mem_req=1, mem_write=1, adr_src=1. Stay until mem_ready, then FETCH.
  - EXECR 6: alu_src_a=10, alu_src_b=00, alu_op=10, funct7_valid=1 -> ALUWB.
  - EXECI 7: alu_src_a=10, alu_src_b=01, alu_op=10, funct7_valid=0 (immediate bit 30 must not select SUB) -> ALUWB.
  - ALUWB 8: result_src=00, reg_write=1 -> FETCH.
  - BEQ 9: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, pc_write=zero -> FETCH.
  - JAL 10: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1 (PC <- target in ALUOut) -> ALUWB (rd <- oldPC+4).
  - ILLEGAL 11: illegal_op=1, no other enables -> FETCH. The instruction is skipped; PC was already advanced in FETCH.
- Codes 12-15 are unreachable. If entered, all outputs 0 and next state = FETCH.
- Cycle counts with zero wait states:
  - lw 5; sw 4; R/I-type 4; beq 3; jal 4; illegal 3.
  - Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- mem_ready outside FETCH, MEMRD or MEMWR is ignored.
- Reset asserted mid-instruction: immediate return to FETCH, no partial write is issued after assertion.
- mem_write is never 1 without mem_req. reg_write and pc_write are never both 1 except FETCH+JAL paths as listed. reg_write is never 1 in FETCH.

Test Plan:
- lw, mem_ready held 0 for 2 cycles in FETCH and 1 cycle in MEMRD -> state_o 0,0,0,1,2,3,3,4,0; reg_write=1 only in state 4 with result_src=01; total 8 cycles.
- beq with zero=1, then beq with zero=0 -> pc_write=1 in state 9 only for the first; alu_op=01 both times; each takes 3 cycles.
- addi with opcode 0010011 (IR bit 30 set), then add with opcode 0110011 -> funct7_valid=0 in state 7, =1 in state 6; alu_op=10 in both.
- jal -> states 0,1,10,8,0; pc_write=1 in 10; reg_write=1 in 8 with result_src=00.
- opcode 1110011 -> states 0,1,11,0; illegal_op high exactly one cycle; mem_req, reg_write and mem_write stay 0 after FETCH.
- sw stalled in MEMWR, rst_n pulsed low mid-stall -> all outputs 0 during reset; first cycle after release is state 0 with mem_write=0.
